switch_cmd_queue: RTL and testbench
===================================

// Module: switch_cmd_queue
// PURPOSE
//  Command buffer and sequencer directly upstream of the dual-switch controller.
//  - Accepts {onoff, address} switch commands from the host interface into a FIFO.
//  - Issues each command as a single-cycle sw_set pulse and holds address/onoff stable
//    until the controller's sw_ready handshake completes.
//  - Issues a controller sw_reset automatically after power-up and on host clear requests.
// PARAMETERS
//  DEPTH    16   FIFO entries; power of 2, minimum 2
//  AW       4    log2(DEPTH)
//  TIMEOUT  255  max cycles in WAIT_LOW or WAIT_HIGH before a fault (SWQ_TIMEOUT_EN builds only)
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  rst_n        in   1  asynchronous, active-low reset
//  cmd_valid    in   1  host command valid
//  cmd_ready    out  1  FIFO can accept; high when not full
//  cmd_data     in   9  {onoff[8], address[7:0]}; address = {AY[7:5], sel[4], AX[3:0]}
//  clr_req      in   1  1-cycle request: flush FIFO, then reset the switches
//  sw_set       out  1  set pulse to controller; exactly 1 cycle wide
//  sw_reset     out  1  reset pulse to controller; exactly 1 cycle wide
//  address      out  8  held address for the current command
//  onoff        out  1  held data for the current command
//  sw_ready     in   1  controller idle/ready
//  busy         out  1  high whenever state != IDLE or FIFO not empty
//  level        out  AW+1  FIFO occupancy, 0..DEPTH
//  done_cnt     out  16  commands completed; wraps 0xFFFF->0
//  fault        out  1  sticky timeout flag (constant 0 when SWQ_TIMEOUT_EN undefined)
// BEHAVIOUR
//  Reset values: all outputs 0, except cmd_ready=1 and busy=1. FIFO empty, state=RST_PULSE.
//  FIFO:
//   - Write when cmd_valid & cmd_ready. Read on the IDLE->SET_PULSE transition.
//   - Write and read in the same cycle are both allowed; level stays unchanged.
//   - A write while full is dropped; level does not change.
//  FSM:
//   - RST_PULSE: sw_reset=1 for 1 cycle -> WAIT_LOW.
//   - IDLE: if FIFO not empty and sw_ready=1: pop, latch address/onoff -> SET_PULSE.
//   - SET_PULSE: sw_set=1 for 1 cycle -> WAIT_LOW.
//   - WAIT_LOW: wait for sw_ready=0 -> WAIT_HIGH. The controller drops ready 2-3 cycles
//     after the pulse.
//   - WAIT_HIGH: wait for sw_ready=1 -> IDLE.
//     - If the last pulse was a set: done_cnt += 1.
//     - If the last pulse was a reset: done_cnt is unchanged.
//  Timing and ordering:
//   - address/onoff change only when a command is popped; they are held otherwise.
//   - Minimum command-to-command spacing equals the controller's round trip; no extra gap.
//   - sw_set and sw_reset are never high in the same cycle.
//   - Both outputs are low for at least 1 cycle between pulses, because the controller
//     edge-detects them.
//  clr_req:
//   - Accepted in any state.
//   - Next cycle: FIFO is empty (level=0) and state=RST_PULSE.
//   - A command mid-flight is abandoned and not counted.
//   - fault is cleared.
//   - A cmd write in the same cycle as clr_req is dropped.
//  After rst_n deassert, the block pulses sw_reset once before any command is issued. The
//  controller is not ready until it has been reset.
// CONFIGURATION
//  SWQ_TIMEOUT_EN defined:
//   - A cycle counter runs in WAIT_LOW/WAIT_HIGH and is zeroed on each state entry.
//   - If the counter reaches TIMEOUT: fault<=1 (sticky), go to RST_PULSE, and the FIFO is
//     retained.
//   - The timed-out command is dropped and not counted.
//  SWQ_TIMEOUT_EN undefined:
//   - No counter; the FSM waits indefinitely.
//   - fault is tied to 0.
// TESTING
//  1. Release rst_n, model controller (ready drops 2 cycles after pulse, rises 6 cycles later)
//     -> exactly one sw_reset pulse, no sw_set; IDLE with done_cnt=0.
//  2. Write 0x105 (onoff=1, addr=0x05) -> one sw_set pulse; address=0x05 and onoff=1 held
//     until ready rises; done_cnt=1.
//  3. Write 16 commands back-to-back while the controller is stalled not-ready
//     -> cmd_ready=0 at level=16; 17th write dropped.
//     Release -> 16 pulses issued in order; done_cnt=16.
//  4. clr_req in WAIT_HIGH with level=5 -> next cycle level=0; one sw_reset pulse;
//     done_cnt unchanged.
//  5. SWQ_TIMEOUT_EN, TIMEOUT=20, controller never drops ready after sw_set
//     -> fault=1 at 20 cycles, then sw_reset issued; clr_req clears fault.
//  6. Simultaneous write and pop at level=1 -> level stays 1; address/onoff reflect the
//     popped entry.

Source files
------------

// File: rtl/switch_cmd_queue.sv
// Command FIFO and pulse sequencer in front of the dual-switch controller.
// Optional watchdog on the controller handshake: define SWQ_TIMEOUT_EN.
module switch_cmd_queue #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [8:0]    cmd_data,
    input  logic          clr_req,
    output logic          sw_set,
    output logic          sw_reset,
    output logic [7:0]    address,
    output logic          onoff,
    input  logic          sw_ready,
    output logic          busy,
    output logic [AW:0]   level,
    output logic [15:0]   done_cnt,
    output logic          fault
);

    if (DEPTH < 2 || DEPTH != (1 << AW) || TIMEOUT < 1) begin : g_param_check
        $error("switch_cmd_queue: DEPTH must be 2**AW and >= 2, TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        RST_PULSE,
        IDLE,
        SET_PULSE,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    state_t        state;
    state_t        state_next;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          wr_en;
    logic          rd_en;
    logic          last_set;
    logic          set_nxt;
    logic          reset_nxt;
    logic          tmo_hit;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_LVL);
    assign wr_en      = cmd_valid && !fifo_full && !clr_req;
    assign rd_en      = (state == IDLE) && (state_next == SET_PULSE);

    // ---- FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SWQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Counter restarts on every state entry so each wait phase gets its own budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state == WAIT_LOW || state == WAIT_HIGH) && state_next == state) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == WAIT_LOW || state == WAIT_HIGH) &&
                     (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (clr_req) begin
            fault <= 1'b0;
        end else if (tmo_hit) begin
            fault <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign fault   = 1'b0;
`endif

    // ---- FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_PULSE;
        end else begin
            state <= state_next;
        end
    end

    // ---- FSM: next state
    always_comb begin
        state_next = state;
        if (clr_req) begin
            state_next = RST_PULSE;
        end else begin
            case (state)
                RST_PULSE: state_next = WAIT_LOW;
                IDLE:      if (!fifo_empty && sw_ready) state_next = SET_PULSE;
                SET_PULSE: state_next = WAIT_LOW;
                WAIT_LOW:  if (tmo_hit) state_next = RST_PULSE;
                           else if (!sw_ready) state_next = WAIT_HIGH;
                WAIT_HIGH: if (tmo_hit) state_next = RST_PULSE;
                           else if (sw_ready) state_next = IDLE;
                default:   state_next = RST_PULSE;
            endcase
        end
    end

    // ---- FSM: outputs
    always_comb begin
        set_nxt   = (state == SET_PULSE) && (state_next == WAIT_LOW);
        reset_nxt = (state == RST_PULSE) && (state_next == WAIT_LOW);
        busy      = (state != IDLE) || !fifo_empty;
        cmd_ready = !fifo_full;
        level     = count;
    end

    // Pulses are registered so they are glitch-free and low while rst_n is asserted;
    // a pulse is only launched when the pulse state actually advances to WAIT_LOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_set   <= 1'b0;
            sw_reset <= 1'b0;
            last_set <= 1'b0;
            address  <= '0;
            onoff    <= 1'b0;
            done_cnt <= '0;
        end else begin
            sw_set   <= set_nxt;
            sw_reset <= reset_nxt;
            if (set_nxt) begin
                last_set <= 1'b1;
            end else if (reset_nxt) begin
                last_set <= 1'b0;
            end
            if (rd_en) begin
                {onoff, address} <= mem[rd_ptr];
            end
            if (state == WAIT_HIGH && state_next == IDLE && last_set) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_switch_cmd_queue.sv
// Scoreboard bench for switch_cmd_queue with a behavioural switch-controller model.
module tb_switch_cmd_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_data;
    logic        clr_req;
    logic        sw_set;
    logic        sw_reset;
    logic [7:0]  address;
    logic        onoff;
    logic        sw_ready;
    logic        busy;
    logic [4:0]  level;
    logic [15:0] done_cnt;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;
    int n_set   = 0;
    int n_reset = 0;
    int exp_done = 0;
    bit prev_pulse = 1'b0;
    logic [8:0] sb [$];

    // Controller model: ready drops 2 cycles after a pulse, rises 6 cycles later.
    int   ctl_t = 0;
    bit   ctl_last_set = 1'b0;
    bit   ctl_stall = 1'b0;
    bit   ctl_nodrop = 1'b0;
    logic ready_q = 1'b0;

    assign sw_ready = ready_q && !ctl_stall;

    always #5 clk = ~clk;

    switch_cmd_queue #(.DEPTH(16), .AW(4), .TIMEOUT(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .clr_req   (clr_req),
        .sw_set    (sw_set),
        .sw_reset  (sw_reset),
        .address   (address),
        .onoff     (onoff),
        .sw_ready  (sw_ready),
        .busy      (busy),
        .level     (level),
        .done_cnt  (done_cnt),
        .fault     (fault)
    );

    always @(posedge clk) begin
        if (!rst_n) begin
            ctl_t   <= 0;
            ready_q <= 1'b0;
        end else if (sw_set || sw_reset) begin
            ctl_t        <= 1;
            ctl_last_set <= sw_set;
        end else if (ctl_t != 0) begin
            if (ctl_t == 2 && !(ctl_nodrop && ctl_last_set)) ready_q <= 1'b0;
            if (ctl_t == 8) begin
                ready_q <= 1'b1;
                ctl_t   <= 0;
            end else begin
                ctl_t <= ctl_t + 1;
            end
        end
    end

    // Pulse monitor and scoreboard pop
    always @(negedge clk) begin
        logic [8:0] exp;
        if (rst_n) begin
            if (sw_set || sw_reset) begin
                n_tests++;
                if ((sw_set && sw_reset) || prev_pulse) begin
                    n_fail++;
                    $display("FAIL pulse_shape: set=%b reset=%b prev_cycle_pulse=%b, required one isolated pulse",
                             sw_set, sw_reset, prev_pulse);
                end
            end
            if (sw_reset) n_reset++;
            if (sw_set) begin
                n_set++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_order: unexpected sw_set with data %h, required no pulse", {onoff, address});
                end else begin
                    exp = sb.pop_front();
                    if ({onoff, address} !== exp) begin
                        n_fail++;
                        $display("FAIL sb_order: issued %h, required %h", {onoff, address}, exp);
                    end
                end
            end
            prev_pulse = sw_set || sw_reset;
        end
    end

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_set(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (sw_set) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; clr_req = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({cmd_ready, busy, sw_set, sw_reset, onoff, fault} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/busy/set/reset/onoff/fault=%b, required 110000",
                     {cmd_ready, busy, sw_set, sw_reset, onoff, fault});
        end
        n_tests++;
        if (level !== 5'd0 || done_cnt !== 16'd0 || address !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data: level=%0d done=%0d addr=%h, required 0 0 00", level, done_cnt, address);
        end
        rst_n = 1'b1;
        wait_idle(100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b, required 0 within 100 cycles", busy);
        end
        n_tests++;
        if (n_reset != 1 || n_set != 0) begin
            n_fail++;
            $display("FAIL reset_pulse: resets=%0d sets=%0d, required 1 0", n_reset, n_set);
        end
        n_tests++;
        if (done_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_done: done_cnt=%0d, required 0", done_cnt);
        end
    endtask

    task automatic test_single();
        bit ok;
        int bad = 0;
        int cyc = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = 9'h105; sb.push_back(9'h105);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_set(20, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_pulse: no sw_set within 20 cycles, required one");
        end
        while (busy && cyc < 50) begin
            if (address !== 8'h05 || onoff !== 1'b1) bad++;
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (bad != 0 || busy) begin
            n_fail++;
            $display("FAIL single_hold: %0d unstable cycles, busy=%b, required 0 and 0", bad, busy);
        end
        exp_done++;
        n_tests++;
        if (done_cnt !== 16'(exp_done)) begin
            n_fail++;
            $display("FAIL single_done: done_cnt=%0d, required %0d", done_cnt, exp_done);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [8:0] d;
        ctl_stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            d = {i[0], 8'(i * 17 + 3)};
            cmd_valid = 1'b1; cmd_data = d; sb.push_back(d);
        end
        @(negedge clk);
        n_tests++;
        if (level !== 5'd16 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: level=%0d ready=%b, required 16 0", level, cmd_ready);
        end
        cmd_data = 9'h1FF;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_tests++;
        if (level !== 5'd16) begin
            n_fail++;
            $display("FAIL b2b_drop: level=%0d, required 16", level);
        end
        ctl_stall = 1'b0;
        wait_idle(1000, ok);
        exp_done += 16;
        n_tests++;
        if (!ok || done_cnt !== 16'(exp_done) || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: idle=%b done=%0d left=%0d, required 1 %0d 0",
                     ok, done_cnt, sb.size(), exp_done);
        end
    endtask

    task automatic test_clear();
        bit ok;
        int r0;
        int s0;
        ctl_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_data = 9'(9'h080 + i); sb.push_back(9'(9'h080 + i));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        ctl_stall = 1'b0;
        wait_set(20, ok);
        for (int i = 0; i < 20 && sw_ready; i++) @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (!ok || sw_ready !== 1'b0 || level !== 5'd5) begin
            n_fail++;
            $display("FAIL clr_setup: set_seen=%b ready=%b level=%0d, required 1 0 5", ok, sw_ready, level);
        end
        r0 = n_reset; s0 = n_set;
        clr_req = 1'b1; cmd_valid = 1'b1; cmd_data = 9'h0AA;
        @(negedge clk);
        clr_req = 1'b0; cmd_valid = 1'b0;
        sb.delete();
        n_tests++;
        if (level !== 5'd0) begin
            n_fail++;
            $display("FAIL clr_flush: level=%0d, required 0", level);
        end
        wait_idle(200, ok);
        n_tests++;
        if (!ok || n_reset != r0 + 1 || n_set != s0 || level !== 5'd0) begin
            n_fail++;
            $display("FAIL clr_reset: idle=%b resets=%0d sets=%0d level=%0d, required 1 %0d %0d 0",
                     ok, n_reset, n_set, level, r0 + 1, s0);
        end
        n_tests++;
        if (done_cnt !== 16'(exp_done)) begin
            n_fail++;
            $display("FAIL clr_done: done_cnt=%0d, required %0d", done_cnt, exp_done);
        end
    endtask

    task automatic test_simul();
        bit ok;
        ctl_stall = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = 9'h033; sb.push_back(9'h033);
        @(negedge clk);
        cmd_data = 9'h1C4; sb.push_back(9'h1C4);
        ctl_stall = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_tests++;
        if (level !== 5'd1) begin
            n_fail++;
            $display("FAIL simul_level: level=%0d, required 1", level);
        end
        n_tests++;
        if ({onoff, address} !== 9'h033) begin
            n_fail++;
            $display("FAIL simul_data: data=%h, required 033", {onoff, address});
        end
        wait_idle(200, ok);
        exp_done += 2;
        n_tests++;
        if (!ok || done_cnt !== 16'(exp_done) || sb.size() != 0) begin
            n_fail++;
            $display("FAIL simul_drain: idle=%b done=%0d left=%0d, required 1 %0d 0",
                     ok, done_cnt, sb.size(), exp_done);
        end
    endtask

`ifdef SWQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int cyc = 0;
        int r0;
        ctl_nodrop = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = 9'h17E; sb.push_back(9'h17E);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_set(20, ok);
        while (!fault && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (!ok || cyc != 20) begin
            n_fail++;
            $display("FAIL tmo_fault: fault after %0d cycles (set_seen=%b), required 20", cyc, ok);
        end
        r0 = n_reset;
        ctl_nodrop = 1'b0;
        wait_idle(200, ok);
        n_tests++;
        if (!ok || n_reset != r0 + 1 || fault !== 1'b1 || done_cnt !== 16'(exp_done)) begin
            n_fail++;
            $display("FAIL tmo_recover: idle=%b resets=%0d fault=%b done=%0d, required 1 %0d 1 %0d",
                     ok, n_reset, fault, done_cnt, r0 + 1, exp_done);
        end
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        n_tests++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_clear: fault=%b, required 0", fault);
        end
        wait_idle(200, ok);
    endtask
`else
    task automatic test_fault_tied();
        n_tests++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_tied: fault=%b, required 0", fault);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_clear();
        test_simul();
`ifdef SWQ_TIMEOUT_EN
        test_timeout();
`else
        test_fault_tied();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
